// File: rtl/imem_stream_loader.sv
// Boot-time instruction-memory loader: parses a length-prefixed, checksummed byte stream,
// writes assembled little-endian words to consecutive imem addresses and releases the core on success.
module imem_stream_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  state_t      state;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] word;
  logic [7:0]  csum;
  logic        accept;
  logic [31:0] len_full;

  assign accept   = rx_valid & rx_ready;
  assign len_full = {16'h0000, rx_data, word_cnt[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_LEN0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word       <= '0;
      csum       <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      // the write cycle presents the current address; advance once it has been used
      if (imem_we) imem_addr <= imem_addr + 32'd4;
      case (state)
        S_LEN0: begin
          rx_ready <= 1'b1;
          if (accept) begin
            word_cnt <= {8'h00, rx_data};
            state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            word_cnt <= {rx_data, word_cnt[7:0]};
            if (len_full > DEPTH) begin
              state    <= S_ERR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end else if (len_full == 32'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum     <= csum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word[7:0]   <= rx_data;
              2'd1: word[15:8]  <= rx_data;
              2'd2: word[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_wdata <= {rx_data, word};
                word_cnt   <= word_cnt - 16'd1;
                if (word_cnt == 16'd1) state <= S_CSUM;
              end
            endcase
          end
        end
        S_CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          // DONE / ERR: only a re-arm pulse leaves; the stream is not sampled here
          if (load_start) begin
            state     <= S_LEN0;
            rx_ready  <= 1'b1;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            csum      <= '0;
            byte_idx  <= '0;
            imem_addr <= BASE_ADDR;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized scoreboard bench for imem_stream_loader: expected writes (address, data, cycle) are
// derived from each image's byte list and checked by an independent write monitor.
module tb_imem_stream_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  imem_stream_loader #(.ADDR_WIDTH(10), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] img[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         hold_chk = 1'b0;
  bit         ls_noise = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // write monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h@%h expected=none (cycle %0d)", imem_wdata, imem_addr, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr, e.addr);
        chk("wr_data", imem_wdata, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (hold_chk) chk("core_hold_during_load", {31'd0, core_hold}, 32'd1);
  end

  task automatic add_csum(input bit bad);
    int cnt;
    int sum;
    cnt = {img[1], img[0]};
    sum = 0;
    for (int i = 0; i < 4 * cnt; i++) sum += img[2 + i];
    img.push_back(8'((sum + (bad ? 1 + $urandom_range(0, 254) : 0)) % 256));
  endtask

  task automatic build_random(input int cnt, input bit bad);
    img.delete();
    img.push_back(cnt[7:0]);
    img.push_back(cnt[15:8]);
    if (cnt <= DEPTH) begin
      for (int i = 0; i < 4 * cnt; i++) img.push_back(8'($urandom_range(0, 255)));
      add_csum(bad);
    end
  endtask

  task automatic build_t1(input bit bad);
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    add_csum(bad);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax,
                           output bit ok, output int hs);
    int t;
    rx_valid = 1'b0;
    repeat ($urandom_range(gmin, gmax)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = rx_ready;
    hs = 0;
    if (!ok) begin
      chk("handshake_timeout", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      hs = cyc;
    end
  endtask

  // stop_at < 0 sends the whole image and checks the final status
  task automatic send_image(input int gmin, input int gmax, input int stop_at);
    int  cnt;
    int  nbytes;
    int  sum;
    bit  ok;
    int  hs;
    bit  exp_done;
    cnt    = {img[1], img[0]};
    nbytes = (cnt > DEPTH) ? 2 : img.size();
    for (int i = 0; i < nbytes; i++) begin
      if (stop_at >= 0 && i == stop_at) return;
      load_start = (ls_noise && i < nbytes - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_byte(img[i], gmin, gmax, ok, hs);
      if (!ok) return;
      if (i >= 2 && i < 2 + 4 * cnt && ((i - 2) % 4) == 3) begin
        wr_t e;
        e.addr = BASE + 32'(4 * ((i - 2) / 4));
        e.data = {img[i], img[i-1], img[i-2], img[i-3]};
        e.cyc  = hs + 1;
        exp_q.push_back(e);
      end
      @(negedge clk);
      rx_valid   = 1'b0;
      load_start = 1'b0;
    end
    sum = 0;
    for (int i = 0; i < 4 * cnt && cnt <= DEPTH; i++) sum += img[2 + i];
    exp_done = (cnt <= DEPTH) && ((sum % 256) == int'(img[img.size() - 1]));
    #1;
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("error", {31'd0, error}, {31'd0, !exp_done});
    chk("core_hold", {31'd0, core_hold}, {31'd0, !exp_done});
    chk("rx_ready_idle", {31'd0, rx_ready}, 32'd0);
    chk("writes_pending", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic rearm(input bit with_byte);
    @(negedge clk);
    load_start = 1'b1;
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
    end
    @(negedge clk);
    load_start = 1'b0;
    rx_valid   = 1'b0;
    #1;
    chk("rearm_core_hold", {31'd0, core_hold}, 32'd1);
    chk("rearm_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rearm_done", {31'd0, done}, 32'd0);
    chk("rearm_error", {31'd0, error}, 32'd0);
    chk("rearm_addr", imem_addr, BASE);
  endtask

  task automatic check_reset_values();
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b1;

    // basic two-word image, then the same with a wrong checksum
    build_t1(1'b0);
    send_image(0, 0, -1);
    rearm(1'b0);
    build_t1(1'b1);
    send_image(0, 0, -1);
    rearm(1'b0);

    // oversize count rejected straight after the length bytes
    build_random(DEPTH + 1, 1'b0);
    send_image(0, 0, -1);
    rearm(1'b0);

    // empty image, good and bad checksum
    build_random(0, 1'b0);
    send_image(0, 2, -1);
    rearm(1'b0);
    build_random(0, 1'b1);
    send_image(0, 2, -1);
    rearm(1'b0);

    // idle gaps between bytes and load_start noise while loading
    ls_noise = 1'b1;
    build_t1(1'b0);
    send_image(1, 5, -1);
    ls_noise = 1'b0;
    rearm(1'b0);

    // reset after six data bytes, then a clean reload
    hold_chk = 1'b1;
    build_t1(1'b0);
    send_image(0, 1, 8);
    reset = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("partial_word_pending", exp_q.size(), 32'd0);
    hold_chk = 1'b0;
    send_image(0, 1, -1);

    // re-arm with a byte offered at the same time: it must not be consumed
    rearm(1'b1);

    for (int n = 0; n < 20; n++) begin
      int cnt;
      cnt = ($urandom_range(0, 7) == 0) ? DEPTH + 1 + $urandom_range(0, 500) : $urandom_range(0, 6);
      build_random(cnt, $urandom_range(0, 3) == 0);
      send_image(0, $urandom_range(0, 3), -1);
      rearm(n[0]);
    end

    // largest legal image fills the memory exactly
    build_random(DEPTH, 1'b0);
    send_image(0, 0, -1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
